mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one MUX4to1 datapath among 4 requesters.

---
 rtl/mux_arb_pkg.sv | 30 +++
 rtl/MUX4to1.sv | 29 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin MUX4to1 arbiter.
//   NREQ          number of requesters sharing the datapath
//   state_e       arbiter FSM encoding (IDLE / GRANT)
//   SEL_R0..R3    one-hot select codes for requester 0..3
//   onehot_to_idx one-hot grant -> binary requester index
package mux_arb_pkg;

   localparam int unsigned NREQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam logic [NREQ-1:0] SEL_R0 = 4'b0001;
   localparam logic [NREQ-1:0] SEL_R1 = 4'b0010;
   localparam logic [NREQ-1:0] SEL_R2 = 4'b0100;
   localparam logic [NREQ-1:0] SEL_R3 = 4'b1000;

   // Input is assumed one-hot (or zero, which maps to index 0).
   function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/MUX4to1.sv
// Four-input word multiplexer with one-hot select.
//   DI0..DI3  in   BITWIDTH  data inputs
//   SEL       in   4         one-hot select; zero or multi-hot drives DO=0
//   DO        out  BITWIDTH  selected word (combinational)
module MUX4to1
   import mux_arb_pkg::*;
#(
   parameter int unsigned BITWIDTH = 32
) (
   input  logic [BITWIDTH-1:0] DI0,
   input  logic [BITWIDTH-1:0] DI1,
   input  logic [BITWIDTH-1:0] DI2,
   input  logic [BITWIDTH-1:0] DI3,
   input  logic [NREQ-1:0]     SEL,
   output logic [BITWIDTH-1:0] DO
);

   always_comb begin
      DO = '0;
      case (SEL)
         SEL_R0:  DO = DI0;
         SEL_R1:  DO = DI1;
         SEL_R2:  DO = DI2;
         SEL_R3:  DO = DI3;
         default: DO = '0;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: returns the first set request scanning from PTR
// upward (mod 4) as a one-hot vector; all-zero when no request is set.
//   REQ       in   4  request vector
//   PTR       in   2  index with highest priority
//   GNT_NEXT  out  4  one-hot pick (combinational)
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NREQ-1:0] REQ,
   input  logic [1:0]      PTR,
   output logic [NREQ-1:0] GNT_NEXT
);

   logic [1:0] scan_idx;
   logic       found;

   always_comb begin
      GNT_NEXT = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         // 2-bit addition wraps 3 -> 0 naturally
         scan_idx = PTR + 2'(i);
         if (!found && REQ[scan_idx]) begin
            GNT_NEXT[scan_idx] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one MUX4to1 among four requesters, with bursts
// capped at MAX_BEATS transfers per grant and same-edge rearbitration.
//   CLK, RST   clock (rising) / asynchronous active-high reset
//   REQ        in   4         per-requester word available
//   DI0..DI3   in   BITWIDTH  requester data
//   OUT_READY  in   1         downstream accepts this cycle
//   GNT        out  4         registered one-hot grant, 0 when idle
//   SEL        out  4         MUX4to1 select, equal to GNT
//   OUT_VALID  out  1         granted requester still requesting (combinational)
//   DO         out  BITWIDTH  MUX4to1 output
//   BUSY       out  1         FSM in GRANT
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned BITWIDTH  = 32,
   parameter int unsigned MAX_BEATS = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     REQ,
   input  logic [BITWIDTH-1:0] DI0,
   input  logic [BITWIDTH-1:0] DI1,
   input  logic [BITWIDTH-1:0] DI2,
   input  logic [BITWIDTH-1:0] DI3,
   input  logic                OUT_READY,
   output logic [NREQ-1:0]     GNT,
   output logic [NREQ-1:0]     SEL,
   output logic                OUT_VALID,
   output logic [BITWIDTH-1:0] DO,
   output logic                BUSY
);

   localparam int unsigned    CW        = $clog2(MAX_BEATS) + 1;
   localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BEATS - 1);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q,   gnt_d;
   logic [1:0]      ptr_q,   ptr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;

   logic [1:0]      gnt_idx;
   logic [1:0]      pick_ptr;
   logic [NREQ-1:0] gnt_next;
   logic            xfer;
   logic            rel;

   assign gnt_idx   = onehot_to_idx(gnt_q);
   assign OUT_VALID = (state_q == GRANT) && |(gnt_q & REQ);
   assign xfer      = OUT_VALID && OUT_READY;
   // Release when the granted requester has dropped or the final beat goes out
   assign rel       = (state_q == GRANT) &&
                      (!OUT_VALID || (xfer && (cnt_q == LAST_BEAT)));
   // On release the pointer moves past the current owner before rearbitrating,
   // so a capped requester that still asks gets lowest priority.
   assign pick_ptr  = rel ? (gnt_idx + 2'd1) : ptr_q;

   assign GNT  = gnt_q;
   assign SEL  = gnt_q;
   assign BUSY = (state_q == GRANT);

   rr_pick4 u_pick (
      .REQ      (REQ),
      .PTR      (pick_ptr),
      .GNT_NEXT (gnt_next)
   );

   MUX4to1 #(.BITWIDTH(BITWIDTH)) u_mux (
      .DI0 (DI0),
      .DI1 (DI1),
      .DI2 (DI2),
      .DI3 (DI3),
      .SEL (gnt_q),
      .DO  (DO)
   );

   // Next-state: arbitration, release and beat counting
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|REQ) begin
               gnt_d   = gnt_next;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_d   = pick_ptr;
               cnt_d   = '0;
               gnt_d   = gnt_next;
               state_d = (|REQ) ? GRANT : IDLE;
            end else if (xfer) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed steps, a cycle model
// feeding an expectation queue, and constant checks for the key scenarios.
module tb_mux4_rr_arbiter;

   localparam int unsigned BW   = 32;
   localparam int          MAXB = 4;

   typedef struct {
      logic [3:0]    gnt;
      logic          valid;
      logic          busy;
      logic [BW-1:0] dat;
      int            ptr;
      int            cnt;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [3:0]    req;
   logic [BW-1:0] di0, di1, di2, di3;
   logic          ready;
   logic [3:0]    gnt, sel;
   logic          valid;
   logic [BW-1:0] dout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_gnt = -1;
   int m_ptr = 0;
   int m_cnt = 0;

   exp_t sb[$];

   mux4_rr_arbiter #(.BITWIDTH(BW), .MAX_BEATS(MAXB)) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ       (req),
      .DI0       (di0),
      .DI1       (di1),
      .DI2       (di2),
      .DI3       (di3),
      .OUT_READY (ready),
      .GNT       (gnt),
      .SEL       (sel),
      .OUT_VALID (valid),
      .DO        (dout),
      .BUSY      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] di_of(input int idx);
      case (idx)
         0:       return di0;
         1:       return di1;
         2:       return di2;
         3:       return di3;
         default: return '0;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (p + k) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   // advance the model across one rising edge
   task automatic model_edge(input logic [3:0] r, input logic rd);
      logic v;
      if (m_gnt < 0) begin
         if (r != 4'b0) m_gnt = pick(r, m_ptr);
      end else begin
         v = r[m_gnt];
         if (!v || (rd && m_cnt == MAXB - 1)) begin
            m_ptr = (m_gnt + 1) % 4;
            m_cnt = 0;
            m_gnt = pick(r, m_ptr);
         end else if (rd) begin
            m_cnt++;
         end
      end
   endtask

   // one cycle: drive at negedge, predict, sample 1ns later, then advance model
   task automatic step(input logic [3:0] r, input logic rd);
      exp_t e;
      @(negedge clk);
      req   = r;
      ready = rd;
      #1;
      e.gnt   = (m_gnt < 0) ? 4'b0000 : 4'(1 << m_gnt);
      e.valid = (m_gnt < 0) ? 1'b0 : r[m_gnt];
      e.busy  = (m_gnt >= 0);
      e.dat   = di_of(m_gnt);
      e.ptr   = m_ptr;
      e.cnt   = m_cnt;
      sb.push_back(e);
      e = sb.pop_front();
      chk("gnt",   32'(gnt),   32'(e.gnt));
      chk("sel",   32'(sel),   32'(e.gnt));
      chk("valid", 32'(valid), 32'(e.valid));
      chk("busy",  32'(busy),  32'(e.busy));
      if (e.valid) chk("do", dout, e.dat);
      chk("ptr", 32'(dut.ptr_q), 32'(e.ptr));
      chk("cnt", 32'(dut.cnt_q), 32'(e.cnt));
      model_edge(r, rd);
   endtask

   initial begin
      int stall_cnt;
      rst   = 1'b1;
      req   = 4'b0000;
      ready = 1'b0;
      di0   = 32'h1111_0000;
      di1   = 32'h2222_0001;
      di2   = 32'd2;
      di3   = 32'h4444_0003;
      #1;
      chk("rst_gnt",   32'(gnt),   32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      @(negedge clk);
      rst = 1'b0;

      // single requester: re-granted at the cap edge with no bubble
      for (int k = 0; k < 10; k++) begin
         step(4'b0100, 1'b1);
         if (k == 0) chk("single_lat", 32'(gnt), 32'h0);
         else begin
            chk("single_gnt", 32'(gnt), 32'h4);
            chk("single_do",  dout,     32'd2);
         end
      end

      // move to requester 3, then drop it: pointer returns to 0
      step(4'b1000, 1'b1);
      step(4'b1000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      chk("idle_gnt",   32'(gnt),        32'h0);
      chk("idle_busy",  32'(busy),       32'h0);
      chk("idle_valid", 32'(valid),      32'h0);
      chk("idle_ptr",   32'(dut.ptr_q),  32'h0);

      // rotation: four cycles per requester, no gaps
      for (int k = 0; k < 20; k++) begin
         step(4'b1111, 1'b1);
         if (k == 0) chk("rot_lat", 32'(gnt), 32'h0);
         else chk("rot_gnt", 32'(gnt), 32'(4'b0001 << (((k - 1) / 4) % 4)));
      end

      // backpressure on requester 0: valid held, counter frozen, data stable
      stall_cnt = m_cnt;
      for (int k = 0; k < 3; k++) begin
         step(4'b0001, 1'b0);
         chk("bp_valid", 32'(valid),       32'h1);
         chk("bp_do",    dout,             32'h1111_0000);
         chk("bp_cnt",   32'(dut.cnt_q),   32'(stall_cnt));
      end
      for (int k = 0; k < 5; k++) step(4'b0001, 1'b1);
      step(4'b0000, 1'b1);

      // early drop of requester 1 after two beats, requester 3 waiting
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      step(4'b1010, 1'b1);
      step(4'b1000, 1'b1);
      step(4'b1000, 1'b1);
      chk("drop_gnt", 32'(gnt),       32'h8);
      chk("drop_ptr", 32'(dut.ptr_q), 32'h2);
      chk("drop_cnt", 32'(dut.cnt_q), 32'h0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      chk("ret_gnt",  32'(gnt),       32'h0);
      chk("ret_busy", 32'(busy),      32'h0);
      chk("ret_ptr",  32'(dut.ptr_q), 32'h0);

      // asynchronous reset mid-burst on requester 1
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b1);
      chk("pre_rst_gnt", 32'(gnt), 32'h2);
      #1 rst = 1'b1;
      #1;
      chk("arst_gnt",   32'(gnt),       32'h0);
      chk("arst_valid", 32'(valid),     32'h0);
      chk("arst_busy",  32'(busy),      32'h0);
      chk("arst_ptr",   32'(dut.ptr_q), 32'h0);
      @(negedge clk);
      rst   = 1'b0;
      req   = 4'b0000;
      m_gnt = -1;
      m_ptr = 0;
      m_cnt = 0;
      step(4'b0010, 1'b1);
      chk("post_rst_idle", 32'(gnt), 32'h0);
      step(4'b0010, 1'b1);
      chk("post_rst_gnt", 32'(gnt), 32'h2);

      // random traffic against the model
      for (int k = 0; k < 300; k++) begin
         logic [3:0] r;
         r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
         di0 = $urandom;
         di1 = $urandom;
         di2 = $urandom;
         di3 = $urandom;
         step(r, ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
